// File: rtl/fmrv32im_axi_arb.sv
// Two-requester AXI4 single-beat master arbiter.
// Grants the instruction side (req0) or data side (req1) round-robin, then runs
// one AXI read or write at a time and returns a one-cycle ACK/ERR to the winner.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   REQ_VALID/WE/ADDR/WDATA/WSTB per-requester request (req1 in upper slices)
//   REQ_ACK/ERR/RDATA            completion pulse, error pulse, shared read data
//   M_AXI_AW*/W*/B*              AXI4 write address, data and response channels
//   M_AXI_AR*/R*                 AXI4 read address and data channels
module fmrv32im_axi_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_WE,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  input  logic [7:0]  REQ_WSTB,
  output logic [1:0]  REQ_ACK,
  output logic [1:0]  REQ_ERR,
  output logic [31:0] REQ_RDATA,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t        state;
  logic          gnt;      // requester owning the current transaction
  logic          prio;     // requester favoured on the next tie
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstb_q;

  logic          gnt_c;
  logic [1:0]    gnt_oh_c;
  logic          aw_fin_c;
  logic          w_fin_c;

  // Round-robin pick: the favoured requester on a tie, otherwise whoever asks.
  always_comb begin
    gnt_c = prio;
    if (REQ_VALID != 2'b11) gnt_c = REQ_VALID[1];
  end

  assign gnt_oh_c = gnt ? 2'b10 : 2'b01;

  // A write channel is finished once its VALID is gone or handshakes this cycle.
  assign aw_fin_c = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_fin_c  = !M_AXI_WVALID  || M_AXI_WREADY;

  // Payload registers feed the AXI buses directly so they stay put under VALID.
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstb_q;

  // Transaction FSM with registered handshake and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      prio          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstb_q        <= '0;
      REQ_ACK       <= '0;
      REQ_ERR       <= '0;
      REQ_RDATA     <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
    end else begin
      REQ_ACK <= '0;
      REQ_ERR <= '0;
      case (state)
        IDLE: begin
          // The ACK cycle still sees the old REQ_VALID, so hold off one cycle.
          if ((REQ_VALID != 2'b00) && (REQ_ACK == 2'b00)) begin
            gnt     <= gnt_c;
            prio    <= ~gnt_c;
            addr_q  <= gnt_c ? REQ_ADDR[63:32]  : REQ_ADDR[31:0];
            wdata_q <= gnt_c ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
            wstb_q  <= gnt_c ? REQ_WSTB[7:4]    : REQ_WSTB[3:0];
            if (REQ_WE[gnt_c]) begin
              state         <= WADDR;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end else begin
              state         <= RADDR;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            REQ_RDATA    <= M_AXI_RDATA;
            REQ_ACK      <= gnt_oh_c;
            REQ_ERR      <= (M_AXI_RRESP != 2'b00) ? gnt_oh_c : 2'b00;
            state        <= IDLE;
          end
        end
        WADDR: begin
          if (aw_fin_c && w_fin_c) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b1;
            state         <= WRESP;
          end else begin
            if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            REQ_ACK      <= gnt_oh_c;
            REQ_ERR      <= (M_AXI_BRESP != 2'b00) ? gnt_oh_c : 2'b00;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmrv32im_axi_arb.sv
// Self-checking bench for fmrv32im_axi_arb: table of single transactions,
// plus sequences for dropped request, reset mid-read, contention and random
// slave ready delays. The AXI slave and protocol monitor act on negedges.
module tb_fmrv32im_axi_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  REQ_VALID = '0;
  logic [1:0]  REQ_WE = '0;
  logic [63:0] REQ_ADDR = '0;
  logic [63:0] REQ_WDATA = '0;
  logic [7:0]  REQ_WSTB = '0;
  logic [1:0]  REQ_ACK;
  logic [1:0]  REQ_ERR;
  logic [31:0] REQ_RDATA;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [1:0]  M_AXI_BRESP = '0;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  fmrv32im_axi_arb dut (
    .clk(clk), .rst_n(rst_n),
    .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTB(REQ_WSTB),
    .REQ_ACK(REQ_ACK), .REQ_ERR(REQ_ERR), .REQ_RDATA(REQ_RDATA),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave configuration, written only by the stimulus process.
  int          cfg_ar = 0, cfg_aw = 0, cfg_w = 0, cfg_r = 0, cfg_b = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

  // Slave / monitor state, written only by the slave process.
  int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, resp_hs = 0, ack_seen = 0, proto_err = 0;
  logic        r_pend = 0, b_pend = 0, r_hs_next = 0, b_hs_next = 0, aw_got = 0, w_got = 0;
  logic        ar_chk = 0, aw_chk = 0, w_chk = 0;
  logic [31:0] ar_hold = '0, aw_hold = '0, w_hold = '0;
  logic [3:0]  ws_hold = '0;
  logic [31:0] seen_araddr = '0, seen_awaddr = '0, seen_wdata = '0;
  logic [3:0]  seen_wstrb = '0;

  // AXI slave with per-channel ready/response delays plus a protocol monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      M_AXI_ARREADY = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
      M_AXI_RVALID = 0; M_AXI_BVALID = 0;
      r_pend = 0; b_pend = 0; r_hs_next = 0; b_hs_next = 0; aw_got = 0; w_got = 0;
      ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
      ar_chk = 0; aw_chk = 0; w_chk = 0;
    end else begin
      // R channel (pending request starts no earlier than the next negedge)
      if (r_hs_next) begin M_AXI_RVALID = 0; r_pend = 0; r_hs_next = 0; end
      if (r_pend && !M_AXI_RVALID) begin
        if (r_wait >= cfg_r) begin
          M_AXI_RVALID = 1; M_AXI_RDATA = cfg_rdata; M_AXI_RRESP = cfg_rresp;
        end else r_wait++;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin r_hs_next = 1; resp_hs++; end
      // B channel
      if (b_hs_next) begin M_AXI_BVALID = 0; b_pend = 0; b_hs_next = 0; end
      if (b_pend && !M_AXI_BVALID) begin
        if (b_wait >= cfg_b) begin M_AXI_BVALID = 1; M_AXI_BRESP = cfg_bresp; end
        else b_wait++;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_hs_next = 1; resp_hs++; end
      // AR channel
      if (ar_chk && (!M_AXI_ARVALID || M_AXI_ARADDR != ar_hold)) proto_err++;
      ar_chk = 0; M_AXI_ARREADY = 0;
      if (M_AXI_ARVALID) begin
        if (ar_wait >= cfg_ar) begin
          M_AXI_ARREADY = 1; ar_wait = 0; ar_hs++; seen_araddr = M_AXI_ARADDR;
          r_pend = 1; r_wait = 0;
        end else begin ar_wait++; ar_chk = 1; ar_hold = M_AXI_ARADDR; end
      end
      // AW channel
      if (aw_chk && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_hold)) proto_err++;
      aw_chk = 0; M_AXI_AWREADY = 0;
      if (M_AXI_AWVALID) begin
        if (aw_wait >= cfg_aw) begin
          M_AXI_AWREADY = 1; aw_wait = 0; aw_hs++; seen_awaddr = M_AXI_AWADDR; aw_got = 1;
        end else begin aw_wait++; aw_chk = 1; aw_hold = M_AXI_AWADDR; end
      end
      // W channel
      if (w_chk && (!M_AXI_WVALID || M_AXI_WDATA != w_hold || M_AXI_WSTRB != ws_hold)) proto_err++;
      w_chk = 0; M_AXI_WREADY = 0;
      if (M_AXI_WVALID) begin
        if (w_wait >= cfg_w) begin
          M_AXI_WREADY = 1; w_wait = 0; w_hs++; seen_wdata = M_AXI_WDATA;
          seen_wstrb = M_AXI_WSTRB; w_got = 1;
        end else begin w_wait++; w_chk = 1; w_hold = M_AXI_WDATA; ws_hold = M_AXI_WSTRB; end
      end
      if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
      // every ACK must follow its own completed response handshake
      if (REQ_ACK != 2'b00) begin
        if (ack_seen >= resp_hs) proto_err++;
        ack_seen++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge, hold it until ACK, return ACK-cycle values.
  // lat counts cycles with the request cycle as 1 and the ACK cycle as the last.
  task automatic do_txn(input int r, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstb,
                        output logic [1:0] ack, output logic [1:0] err,
                        output logic [31:0] rd, output int lat);
    REQ_WE[r] = we;
    REQ_ADDR[r*32 +: 32] = addr;
    REQ_WDATA[r*32 +: 32] = wdata;
    REQ_WSTB[r*4 +: 4] = wstb;
    REQ_VALID[r] = 1'b1;
    lat = 1;
    do begin @(negedge clk); lat++; end while (REQ_ACK == 2'b00 && lat < 200);
    ack = REQ_ACK; err = REQ_ERR; rd = REQ_RDATA;
    REQ_VALID[r] = 1'b0;
  endtask

  typedef struct {
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          d_a;     // AR or AW ready delay
    int          d_w;     // W ready delay
    int          d_r;     // R or B response delay
    logic [1:0]  exp_ack;
    logic [1:0]  exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [8];
  vec_t        v;
  logic [1:0]  ack, err;
  logic [31:0] rd;
  int          lat, n, ar0, aw0, w0;
  int          rq, wr, exp_lat;
  logic [1:0]  oh;

  initial begin
    vecs[0] = '{0, 1'b0, 32'h0000_0800, 32'h0,         4'h0, 32'h0000_0001, 2'b00, 0, 0, 0, 2'b01, 2'b00, 4};
    vecs[1] = '{1, 1'b1, 32'h0000_0800, 32'h0000_0001, 4'hF, 32'h0,         2'b00, 0, 3, 0, 2'b10, 2'b00, 7};
    vecs[2] = '{1, 1'b0, 32'h1000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b10, 2, 0, 1, 2'b10, 2'b10, 7};
    vecs[3] = '{0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 32'h0,         2'b11, 2, 0, 1, 2'b01, 2'b01, 7};
    vecs[4] = '{0, 1'b1, 32'h0000_0044, 32'h1234_5678, 4'h8, 32'h0,         2'b00, 1, 1, 0, 2'b01, 2'b00, 5};
    vecs[5] = '{1, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hA5A5_5A5A, 2'b01, 0, 0, 3, 2'b10, 2'b10, 7};
    vecs[6] = '{0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00, 4, 0, 2, 2'b01, 2'b00, 10};
    vecs[7] = '{0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b00, 7, 0, 7, 2'b01, 2'b00, 18};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(REQ_ACK), 32'h0);
    chk("rst_err", 32'(REQ_ERR), 32'h0);
    chk("rst_rdata", REQ_RDATA, 32'h0);
    chk("rst_axi_valid_ready",
        32'({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY}), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single transactions from the vector table
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      cfg_rdata = v.rdata; cfg_rresp = v.resp; cfg_bresp = v.resp;
      cfg_ar = v.d_a; cfg_aw = v.d_a; cfg_w = v.d_w; cfg_r = v.d_r; cfg_b = v.d_r;
      ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
      do_txn(v.req, v.we, v.addr, v.wdata, v.wstb, ack, err, rd, lat);
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(v.exp_ack));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
      chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
      if (v.we) begin
        chk($sformatf("v%0d_awaddr", i), seen_awaddr, v.addr);
        chk($sformatf("v%0d_wdata", i), seen_wdata, v.wdata);
        chk($sformatf("v%0d_wstrb", i), 32'(seen_wstrb), 32'(v.wstb));
        chk($sformatf("v%0d_aw_w_count", i), 32'({16'(aw_hs - aw0), 16'(w_hs - w0)}), 32'h0001_0001);
      end else begin
        chk($sformatf("v%0d_araddr", i), seen_araddr, v.addr);
        chk($sformatf("v%0d_rdata", i), rd, v.rdata);
        chk($sformatf("v%0d_ar_count", i), ar_hs - ar0, 1);
      end
      @(negedge clk);
      chk($sformatf("v%0d_ack_one_cycle", i), 32'(REQ_ACK), 32'h0);
    end

    // Requester drops REQ_VALID one cycle in; the write still completes.
    cfg_aw = 3; cfg_w = 3; cfg_b = 2; cfg_bresp = 2'b00;
    REQ_WE[0] = 1'b1; REQ_ADDR[31:0] = 32'h300; REQ_WDATA[31:0] = 32'h5; REQ_WSTB[3:0] = 4'hF;
    REQ_VALID[0] = 1'b1;
    @(negedge clk);
    REQ_VALID[0] = 1'b0;
    n = 1;
    do begin @(negedge clk); n++; end while (REQ_ACK == 2'b00 && n < 50);
    chk("drop_ack", 32'(REQ_ACK), 32'h1);
    chk("drop_latency", n + 1, 9);
    chk("drop_awaddr", seen_awaddr, 32'h300);
    @(negedge clk);

    // Reset while the read is waiting in RDATA.
    cfg_ar = 0; cfg_r = 5; cfg_rdata = 32'h1111_2222; cfg_rresp = 2'b00;
    REQ_WE[0] = 1'b0; REQ_ADDR[31:0] = 32'h100; REQ_VALID[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!M_AXI_RREADY && n < 20);
    chk("rst_mid_in_rdata", 32'(M_AXI_RREADY), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valids",
        32'({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY}), 32'h0);
    chk("rst_mid_ack", 32'({REQ_ACK, REQ_ERR}), 32'h0);
    REQ_VALID[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cfg_r = 0; cfg_rdata = 32'h55;
    do_txn(1, 1'b0, 32'h900, 32'h0, 4'h0, ack, err, rd, lat);
    chk("post_rst_ack", 32'(ack), 32'h2);
    chk("post_rst_rdata", rd, 32'h55);
    chk("post_rst_araddr", seen_araddr, 32'h900);
    chk("post_rst_latency", lat, 4);
    @(negedge clk);

    // Fresh reset, then both requesters held for six reads.
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cfg_ar = 0; cfg_r = 0; cfg_rdata = 32'h77;
    REQ_WE = 2'b00; REQ_ADDR = {32'h2000, 32'h1000}; REQ_VALID = 2'b11;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (REQ_ACK == 2'b00 && n < 50);
      chk($sformatf("cont%0d_grant", t), 32'(REQ_ACK), (t % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("cont%0d_addr", t), seen_araddr, (t % 2 == 0) ? 32'h1000 : 32'h2000);
      chk($sformatf("cont%0d_gap", t), n, (t == 0) ? 3 : 4);
    end
    REQ_VALID = 2'b00;
    @(negedge clk);

    // Random ready/response delays of 0-7 cycles on every channel.
    for (int k = 0; k < 12; k++) begin
      rq = int'($urandom_range(0, 1)); wr = int'($urandom_range(0, 1));
      cfg_ar = int'($urandom_range(0, 7)); cfg_aw = int'($urandom_range(0, 7));
      cfg_w = int'($urandom_range(0, 7)); cfg_r = int'($urandom_range(0, 7));
      cfg_b = int'($urandom_range(0, 7));
      cfg_rdata = $urandom; cfg_rresp = 2'($urandom_range(0, 3)); cfg_bresp = 2'($urandom_range(0, 3));
      oh = (rq == 1) ? 2'b10 : 2'b01;
      if (wr == 1) exp_lat = 4 + ((cfg_aw > cfg_w) ? cfg_aw : cfg_w) + cfg_b;
      else         exp_lat = 4 + cfg_ar + cfg_r;
      do_txn(rq, wr[0], $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)), ack, err, rd, lat);
      chk($sformatf("rnd%0d_ack", k), 32'(ack), 32'(oh));
      chk($sformatf("rnd%0d_err", k), 32'(err),
          32'((((wr == 1) ? cfg_bresp : cfg_rresp) != 2'b00) ? oh : 2'b00));
      chk($sformatf("rnd%0d_latency", k), lat, exp_lat);
      if (wr == 0) chk($sformatf("rnd%0d_rdata", k), rd, cfg_rdata);
      @(negedge clk);
    end

    chk("protocol_violations", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fmrv32im_axi_arb.md
FMRV32IM_AXI_ARB -- requirements
Module: fmrv32im_axi_arb

Interface
REQ-001 rst_n  input  1  asynchronous active-low reset.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 REQ_VALID  input  2  per-requester request (bit0 = instruction side, bit1 = data side), held until ACK.
REQ-004 REQ_WE  input  2  per-requester write enable; 0 = read.
REQ-005 REQ_ADDR  input  64  per-requester byte address; [31:0] is req0, [63:32] is req1.
REQ-006 REQ_WDATA  input  64  per-requester write data, same packing as REQ_ADDR.
REQ-007 REQ_WSTB  input  8  per-requester byte strobes; [3:0] is req0, [7:4] is req1.
REQ-008 REQ_ACK  output  2  one-cycle completion pulse to the granted requester.
REQ-009 REQ_ERR  output  2  one-cycle error pulse, coincident with REQ_ACK.
REQ-010 REQ_RDATA  output  32  shared read data, valid only in the REQ_ACK cycle of a read.
REQ-011 M_AXI_AWADDR / M_AXI_AWVALID  output  32 / 1  AXI4 write address channel.
REQ-012 M_AXI_AWREADY  input  1  AXI4 write address ready.
REQ-013 M_AXI_WDATA / M_AXI_WSTRB / M_AXI_WVALID  output  32 / 4 / 1  AXI4 write data; WLAST is tied high by the parent.
REQ-014 M_AXI_WREADY  input  1  AXI4 write data ready.
REQ-015 M_AXI_BRESP / M_AXI_BVALID  input  2 / 1  AXI4 write response.
REQ-016 M_AXI_BREADY  output  1  AXI4 write response ready.
REQ-017 M_AXI_ARADDR / M_AXI_ARVALID  output  32 / 1  AXI4 read address channel.
REQ-018 M_AXI_ARREADY  input  1  AXI4 read address ready.
REQ-019 M_AXI_RDATA / M_AXI_RRESP / M_AXI_RVALID  input  32 / 2 / 1  AXI4 read data channel; RLAST is ignored.
REQ-020 M_AXI_RREADY  output  1  AXI4 read data ready.
REQ-021 The parent SHALL tie the remaining AXI fields as constants: LEN=0, SIZE=3'b010, BURST=2'b01, ID/LOCK/CACHE/PROT/QOS/USER=0.

Function
REQ-022 The FSM SHALL have states IDLE, RADDR, RDATA, WADDR, WRESP; at most one AXI transaction is outstanding.
REQ-023 In IDLE with any REQ_VALID high, the block SHALL grant one requester, latch its addr/wdata/wstb/we, and move to RADDR (we=0) or WADDR (we=1) on the next edge.
REQ-024 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the pointer updates only on grant; the post-reset pointer favours req0.
REQ-025 RADDR: ARVALID=1 and ARADDR=latched address; on ARREADY go to RDATA with ARVALID=0.
REQ-026 RDATA: RREADY=1; on RVALID, register RDATA into REQ_RDATA and pulse REQ_ACK[g] the following cycle, then return to IDLE.
REQ-027 WADDR: AWVALID and WVALID SHALL assert together; each deasserts independently on its own handshake, including handshakes in the same cycle or either order; go to WRESP once both are done.
REQ-028 WRESP: BREADY=1; on BVALID pulse REQ_ACK[g] the following cycle, then return to IDLE.
REQ-029 REQ_ERR[g] SHALL pulse with ACK when RRESP or BRESP is nonzero; REQ_RDATA still carries RDATA.
REQ-030 VALID signals SHALL stay stable until their handshake; address/data SHALL NOT change while VALID is high.
REQ-031 Minimum latency, REQ_VALID to REQ_ACK with zero-wait slave: read 4 cycles, write 4 cycles.
REQ-032 A requester dropping REQ_VALID mid-transaction SHALL NOT abort it; the transaction completes and ACK is still pulsed.
REQ-033 REQ_ACK SHALL NOT pulse for a non-granted requester; no new grant is made in the ACK cycle, so arbitration resumes in IDLE the cycle after.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, all AXI VALID/READY=0, REQ_ACK=0, REQ_ERR=0, REQ_RDATA=0, RR pointer=req0; an in-flight transaction is abandoned.

Verification
REQ-035 Single read: req0 addr 0x800, slave RDATA 0x1 with zero wait -> ARADDR=0x800, REQ_ACK=2'b01 with REQ_RDATA=0x1, REQ_ERR=0.
REQ-036 Write: req1 addr 0x800, wdata 0x1, wstb 0xF, WREADY 3 cycles after AWREADY -> single AW, single W, REQ_ACK=2'b10 after BVALID.
REQ-037 Contention: both requests held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-038 Error: slave returns RRESP=2'b10 -> REQ_ACK and REQ_ERR pulse together for the granted requester.
REQ-039 Reset mid-transaction: rst_n low while in RDATA -> all VALIDs drop at once; after release, a req1 read completes normally.
REQ-040 Protocol checker: VALID is held stable until READY across random ready delays of 0-7 cycles; no ACK is issued without a prior completed handshake.
